// File: rtl/mipi_dphy_pkg.sv
// Shared D-PHY HS receive definitions: byte width, default sync byte and aligner FSM states.
package mipi_dphy_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hB8;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StSkew,
        StStream,
        StFail
    } align_state_e;

endpackage

// File: rtl/mipi_lane_sync_hunter.sv
// Per-lane HS sync hunter: finds the sync byte at any bit offset, then emits bytes re-framed
// at the locked offset until cleared.
module mipi_lane_sync_hunter
    import mipi_dphy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SyncByte = SYNC_BYTE_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hunt_i,
    input  logic              clear_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              hit_o,
    output logic              locked_o,
    output logic [2:0]        offset_o,
    output logic [BYTE_W-1:0] aligned_o
);

    logic [BYTE_W-1:0]   prev_q;
    logic                locked_q, locked_d;
    logic [2:0]          offset_q, offset_d;
    logic [2*BYTE_W-2:0] win;
    logic                match;
    logic [2:0]          match_off;

    // Bit 15 of the full {cur, prev} window is never part of any candidate.
    assign win = {data_i[BYTE_W-2:0], prev_q};

    always_comb begin
        match     = 1'b0;
        match_off = '0;
        // Descending scan so the lowest matching offset wins.
        for (int k = BYTE_W - 1; k >= 0; k--) begin
            if (win[k +: BYTE_W] == SyncByte) begin
                match     = 1'b1;
                match_off = 3'(k);
            end
        end
    end

    assign hit_o = hunt_i && !locked_q && match;

    always_comb begin
        locked_d = locked_q;
        offset_d = offset_q;
        if (clear_i) begin
            locked_d = 1'b0;
            offset_d = '0;
        end else if (hit_o) begin
            locked_d = 1'b1;
            offset_d = match_off;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= '0;
            locked_q <= 1'b0;
            offset_q <= '0;
        end else begin
            prev_q   <= data_i;
            locked_q <= locked_d;
            offset_q <= offset_d;
        end
    end

    assign locked_o  = locked_q;
    assign offset_o  = offset_q;
    assign aligned_o = locked_q ? win[offset_q +: BYTE_W] : '0;

endmodule

// File: rtl/mipi_hs_lane_aligner.sv
// N-lane D-PHY HS aligner: per-lane sync hunt, inter-lane deskew via short delay lines,
// burst-level timeout/skew failure reporting.
module mipi_hs_lane_aligner
    import mipi_dphy_pkg::*;
#(
    parameter int unsigned       LANES        = 2,
    parameter int unsigned       ALIGN_DEPTH  = 4,
    parameter logic [BYTE_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned       SYNC_TIMEOUT = 64
) (
    input  logic                      byte_clk,
    input  logic                      reset,
    input  logic                      hs_burst_flag,
    input  logic [BYTE_W*LANES-1:0]   lanes_data_in,
    output logic [BYTE_W*LANES-1:0]   lanes_data_out,
    output logic                      lanes_data_out_valid,
    output logic [LANES-1:0]          lane_locked,
    output logic [3*LANES-1:0]        lane_bit_offset,
    output logic                      align_fail
);

    localparam int unsigned PtrW = (ALIGN_DEPTH > 1) ? $clog2(ALIGN_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SYNC_TIMEOUT + ALIGN_DEPTH + 1);

    align_state_e              state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      fail_q, fail_d;
    logic                      armed_q, armed_d;
    logic                      valid_q, valid_d;
    logic [BYTE_W*LANES-1:0]   out_q, out_d;
    logic [PtrW-1:0]           wptr_q, wptr_d;
    logic [PtrW-1:0]           dly_q [LANES];
    logic [PtrW-1:0]           dly_d [LANES];
    logic [PtrW-1:0]           rd_idx [LANES];
    logic [BYTE_W-1:0]         dl_q [LANES][ALIGN_DEPTH];
    logic [BYTE_W-1:0]         aligned [LANES];
    logic [2:0]                offset [LANES];
    logic [LANES-1:0]          hit;
    logic [LANES-1:0]          locked;
    logic                      hunt;
    logic                      all_lock_now;

    assign hunt = hs_burst_flag && (state_q == StHunt || state_q == StSkew);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        mipi_lane_sync_hunter #(
            .SyncByte (SYNC_BYTE)
        ) u_hunter (
            .clk_i     (byte_clk),
            .rst_i     (reset),
            .hunt_i    (hunt),
            .clear_i   (!hs_burst_flag),
            .data_i    (lanes_data_in[g*BYTE_W +: BYTE_W]),
            .hit_o     (hit[g]),
            .locked_o  (locked[g]),
            .offset_o  (offset[g]),
            .aligned_o (aligned[g])
        );
        assign lane_bit_offset[3*g +: 3] = offset[g];
    end

    // Counts lanes locking this very cycle, so simultaneous locks go straight to stream.
    assign all_lock_now = &(locked | hit);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        fail_d  = fail_q;
        armed_d = armed_q | !hs_burst_flag;
        if (!hs_burst_flag) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    // Only a fresh rising edge of the burst flag starts a hunt.
                    if (armed_q) begin
                        state_d = StHunt;
                        cnt_d   = '0;
                        fail_d  = 1'b0;
                        armed_d = 1'b0;
                    end
                end
                StHunt: begin
                    if (all_lock_now) begin
                        state_d = StStream;
                    end else if (|hit) begin
                        state_d = StSkew;
                        cnt_d   = '0;
                    end else if (cnt_d == CntW'(SYNC_TIMEOUT)) begin
                        state_d = StFail;
                        fail_d  = 1'b1;
                    end
                end
                StSkew: begin
                    if (all_lock_now) begin
                        state_d = StStream;
                    end else if (cnt_d == CntW'(ALIGN_DEPTH - 1)) begin
                        state_d = StFail;
                        fail_d  = 1'b1;
                    end
                end
                StStream: state_d = StStream;
                StFail:   state_d = StFail;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Each locked lane accrues one cycle of delay for every cycle some lane is still unlocked.
    always_comb begin
        wptr_d  = (wptr_q == PtrW'(ALIGN_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        valid_d = hs_burst_flag && (state_q == StStream);
        out_d   = '0;
        for (int i = 0; i < LANES; i++) begin
            dly_d[i] = dly_q[i];
            if (state_q == StIdle) begin
                dly_d[i] = '0;
            end else if (hunt) begin
                if (hit[i]) begin
                    dly_d[i] = '0;
                end else if (locked[i] && !(&locked)) begin
                    dly_d[i] = dly_q[i] + 1'b1;
                end
            end
            rd_idx[i] = (wptr_q >= dly_q[i]) ? wptr_q - dly_q[i]
                                              : wptr_q + PtrW'(ALIGN_DEPTH) - dly_q[i];
            if (valid_d) begin
                out_d[i*BYTE_W +: BYTE_W] = (dly_q[i] == '0) ? aligned[i] : dl_q[i][rd_idx[i]];
            end
        end
    end

    always_ff @(posedge byte_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            armed_q <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
            wptr_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                dly_q[i] <= '0;
                for (int j = 0; j < ALIGN_DEPTH; j++) begin
                    dl_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            armed_q <= armed_d;
            valid_q <= valid_d;
            out_q   <= out_d;
            wptr_q  <= wptr_d;
            for (int i = 0; i < LANES; i++) begin
                dly_q[i]         <= dly_d[i];
                dl_q[i][wptr_q]  <= aligned[i];
            end
        end
    end

    assign lanes_data_out       = out_q;
    assign lanes_data_out_valid = valid_q;
    assign lane_locked          = locked;
    assign align_fail           = fail_q;

endmodule
